// File: rtl/vram_dp_fill.sv
// Dual-port character RAM: host port A (req/ack), display port B (2-cycle read) and a clear engine.
// Define VRAM_SCROLL_EN to compile in the one-row scroll-up engine.
module vram_dp_fill #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 10,
  parameter int                COLS      = 64,
  parameter int                ROWS      = 16,
  parameter logic [DATA_W-1:0] FILL_CHAR = DATA_W'(8'h20)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_ack,
  input  logic              b_en,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_valid,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              scroll_start,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH  = 2**ADDR_W;
  localparam int SCREEN = COLS * ROWS;
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  if (SCREEN > DEPTH) begin : g_geometry_check
    $error("vram_dp_fill: COLS*ROWS exceeds RAM depth");
  end

`ifdef VRAM_SCROLL_EN
  localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] SCR_LAST   = ADDR_W'(SCREEN - 1);
  localparam logic [ADDR_W-1:0] BLANK_BASE = ADDR_W'(COLS * (ROWS - 1));
`else
  logic unused_scroll;
  assign unused_scroll = scroll_start;
`endif

  typedef enum logic [2:0] {
    IDLE,
    FILL
`ifdef VRAM_SCROLL_EN
    , SCR_RD,
    SCR_WR,
    SCR_BLANK
`endif
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic              done_q, done_d;
  logic              a_ack_q;
  logic [DATA_W-1:0] a_rd_q, b_rd_q, b_dout_q;
  logic              b_pend_q, b_valid_q;

  logic              start_fire, host_fire, eng_we;
  logic [ADDR_W-1:0] eng_addr, a_rd_addr;
  logic [DATA_W-1:0] eng_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    val_d      = val_q;
    done_d     = 1'b0;
    start_fire = 1'b0;
    eng_we     = 1'b0;
    eng_addr   = addr_q;
    eng_data   = val_q;
    a_rd_addr  = a_addr;
    case (state_q)
      IDLE: begin
        if (fill_start) begin
          start_fire = 1'b1;
          state_d    = FILL;
          addr_d     = '0;
          val_d      = fill_value;
        end
`ifdef VRAM_SCROLL_EN
        else if (scroll_start) begin
          start_fire = 1'b1;
          state_d    = SCR_RD;
          addr_d     = COLS_A;
          val_d      = fill_value;
        end
`endif
      end
      FILL: begin
        eng_we = 1'b1;
        addr_d = addr_q + ONE;
        if (addr_q == '1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`ifdef VRAM_SCROLL_EN
      // Port A's read register doubles as the scroll source latch.
      SCR_RD: begin
        a_rd_addr = addr_q;
        state_d   = SCR_WR;
      end
      SCR_WR: begin
        eng_we   = 1'b1;
        eng_addr = addr_q - COLS_A;
        eng_data = a_rd_q;
        if (addr_q == SCR_LAST) begin
          state_d = SCR_BLANK;
          addr_d  = BLANK_BASE;
        end else begin
          state_d = SCR_RD;
          addr_d  = addr_q + ONE;
        end
      end
      SCR_BLANK: begin
        eng_we = 1'b1;
        addr_d = addr_q + ONE;
        if (addr_q == SCR_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // The ack cycle itself is never a new request; a start in the same cycle beats the host.
  assign host_fire = (state_q == IDLE) && a_req && !a_ack_q && !start_fire;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = eng_addr;
    mem_wdata = eng_data;
    if (!reset) begin
      if (eng_we) begin
        mem_we = 1'b1;
      end else if (host_fire && a_we) begin
        mem_we    = 1'b1;
        mem_waddr = a_addr;
        mem_wdata = a_din;
      end
    end
  end

  // NOTE: the array and its read registers stay out of reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    a_rd_q <= mem[a_rd_addr];
    b_rd_q <= mem[b_addr];
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FILL;
      addr_q    <= '0;
      val_q     <= FILL_CHAR;
      done_q    <= 1'b0;
      a_ack_q   <= 1'b0;
      b_pend_q  <= 1'b0;
      b_valid_q <= 1'b0;
      b_dout_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      val_q     <= val_d;
      done_q    <= done_d;
      a_ack_q   <= host_fire;
      b_pend_q  <= b_en;
      b_valid_q <= b_pend_q;
      if (b_pend_q) b_dout_q <= b_rd_q;
    end
  end

  assign a_ack   = a_ack_q;
  assign a_dout  = a_ack_q ? a_rd_q : '0;
  assign b_dout  = b_dout_q;
  assign b_valid = b_valid_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_vram_dp_fill.sv
// Directed + randomized bench for vram_dp_fill against an array model of screen memory.
module tb_vram_dp_fill;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int COLS   = 64;
  localparam int ROWS   = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              a_req = 1'b0, a_we = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
  logic [DATA_W-1:0] a_din = '0, fill_value = '0;
  logic              b_en = 1'b0, fill_start = 1'b0, scroll_start = 1'b0;
  logic [DATA_W-1:0] a_dout, b_dout;
  logic              a_ack, b_valid, busy, done;

  logic [7:0] model [DEPTH];
  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  vram_dp_fill dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout), .a_ack(a_ack),
    .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout), .b_valid(b_valid),
    .fill_start(fill_start), .fill_value(fill_value), .scroll_start(scroll_start),
    .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_fill(input logic [7:0] v);
    for (int i = 0; i < DEPTH; i++) model[i] = v;
  endtask

  task automatic model_scroll(input logic [7:0] blank);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        model[r*COLS + c] = (r == ROWS-1) ? blank : model[(r+1)*COLS + c];
  endtask

  // Counts busy cycles from the current sample point; leaves the bench on the busy-fall cycle.
  task automatic count_busy(input string tag, input int exp_n);
    int n = 0;
    bit spur = 1'b0;
    while (busy === 1'b1 && n < 5000) begin
      if (a_ack !== 1'b0 || done !== 1'b0) spur = 1'b1;
      n++;
      tick();
    end
    check({tag, "_busy_len"}, n, exp_n);
    check({tag, "_quiet"}, spur, 0);
    check({tag, "_done"}, done, 1);
  endtask

  task automatic host_op(input bit we, input logic [9:0] addr, input logic [7:0] din,
                         input string tag);
    int w;
    a_req = 1'b1; a_we = we; a_addr = addr; a_din = din;
    tick();
    w = 1;
    while (a_ack !== 1'b1 && w < 3000) begin
      tick();
      w++;
    end
    check({tag, "_ack_lat"}, w, 1);
    if (!we) check({tag, "_rdata"}, a_dout, model[addr]);
    else model[addr] = din;
    a_req = 1'b0;
    tick();
    check({tag, "_ack_pulse"}, a_ack, 0);
  endtask

  task automatic b_single(input logic [9:0] addr, input string tag);
    b_en = 1'b1; b_addr = addr;
    tick();
    b_en = 1'b0;
    tick();
    check({tag, "_valid"}, b_valid, 1);
    check({tag, "_data"}, b_dout, model[addr]);
  endtask

  // Streams one display read per cycle over the whole RAM.
  task automatic b_sweep(input string tag);
    bit bad_valid = 1'b0;
    for (int t = 0; t < DEPTH + 2; t++) begin
      if (t >= 2) begin
        if (b_valid !== 1'b1) bad_valid = 1'b1;
        check($sformatf("%s_b[%0d]", tag, t - 2), b_dout, model[t - 2]);
      end
      b_en   = (t < DEPTH);
      b_addr = ADDR_W'(t);
      tick();
    end
    b_en = 1'b0;
    check({tag, "_b_valid"}, bad_valid, 0);
  endtask

  initial begin
    logic [9:0] ra;
    logic [7:0] rd;
    bit         rw;

    // Reset values.
    tick(); tick();
    check("rst_a_ack", a_ack, 0);
    check("rst_a_dout", a_dout, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_b_dout", b_dout, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 1);

    // Automatic post-reset clear.
    reset = 1'b0;
    model_fill(8'h20);
    count_busy("por", 1024);
    tick();
    check("por_done_pulse", done, 0);
    b_sweep("por");

    // Host write / read of 0x0C5 and display read.
    host_op(1'b1, 10'h0C5, 8'h41, "wr_c5");
    host_op(1'b0, 10'h0C5, 8'h00, "rd_c5");
    check("rd_c5_model", model[10'h0C5], 8'h41);
    b_single(10'h0C5, "b_c5");

    // Read-first collision, then a B read one cycle later, then b_en low.
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'h010; a_din = 8'h55;
    b_en = 1'b1; b_addr = 10'h010;
    tick();
    check("col_ack", a_ack, 1);
    a_req = 1'b0;
    tick();
    check("col_valid", b_valid, 1);
    check("col_old", b_dout, 8'h20);
    b_en = 1'b0;
    tick();
    check("col_new", b_dout, 8'h55);
    model[10'h010] = 8'h55;
    tick();
    check("col_idle_valid", b_valid, 0);
    check("col_hold", b_dout, 8'h55);

    // Randomized host traffic.
    for (int i = 0; i < 64; i++) begin
      ra = 10'($urandom_range(0, DEPTH - 1));
      rd = 8'($urandom);
      rw = 1'($urandom);
      host_op(rw, ra, rd, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 3)) tick();
    end
    b_sweep("rand");

    // Fill with 0 racing a host write: engine wins, host acks one cycle after busy falls.
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'h123; a_din = 8'hA5;
    fill_start = 1'b1; fill_value = 8'h00;
    tick();
    fill_start = 1'b0;
    model_fill(8'h00);
    count_busy("fill0", 1024);
    check("fill0_no_ack_at_fall", a_ack, 0);
    tick();
    check("fill0_host_ack", a_ack, 1);
    check("fill0_done_pulse", done, 0);
    model[10'h123] = 8'hA5;
    a_req = 1'b0;
    tick();
    check("fill0_ack_pulse", a_ack, 0);
    b_sweep("fill0");

`ifdef VRAM_SCROLL_EN
    // Row r holds r, then scroll up one row with blank 0x20.
    for (int a = 0; a < DEPTH; a++)
      host_op(1'b1, 10'(a), 8'(a / COLS), $sformatf("row%0d", a));
    scroll_start = 1'b1; fill_value = 8'h20;
    tick();
    scroll_start = 1'b0;
    count_busy("scroll", 2*COLS*(ROWS-1) + COLS);
    model_scroll(8'h20);
    tick();
    b_sweep("scroll");

    // Fill and scroll in the same cycle: fill wins.
    fill_start = 1'b1; scroll_start = 1'b1; fill_value = 8'h33;
    tick();
    fill_start = 1'b0; scroll_start = 1'b0;
    model_fill(8'h33);
    count_busy("both", 1024);
    tick();
    b_sweep("both");
`else
    // Without the scroll engine a scroll request does nothing.
    scroll_start = 1'b1; fill_value = 8'h99;
    tick();
    scroll_start = 1'b0;
    check("noscroll_busy", busy, 0);
    tick();
    check("noscroll_done", done, 0);
    b_single(10'h000, "noscroll_b0");
    b_single(10'h3FF, "noscroll_b3ff");
`endif

    // Reset 300 cycles into a fill, with a host read pending throughout.
    fill_start = 1'b1; fill_value = 8'h77;
    tick();
    fill_start = 1'b0;
    repeat (300) tick();
    check("mid_busy", busy, 1);
    reset = 1'b1; a_req = 1'b1; a_we = 1'b0; a_addr = 10'h005;
    tick(); tick();
    check("mid_rst_ack", a_ack, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_busy", busy, 1);
    reset = 1'b0;
    model_fill(8'h20);
    count_busy("refill", 1024);
    check("refill_no_ack_at_fall", a_ack, 0);
    tick();
    check("refill_host_ack", a_ack, 1);
    check("refill_host_data", a_dout, 8'h20);
    a_req = 1'b0;
    tick();
    check("refill_ack_pulse", a_ack, 0);
    b_sweep("refill");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
